mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sole owner of the 8-bit single-port RAM bus. It serves two requesters: IF (instruction word fetch)
//  and MEM (load/store of 1/2/4 bytes). It splits each access into byte transfers and reassembles them
//  little-endian, then returns a one-cycle done pulse. It sits between IF/MEM and the top-level ram port.
//  Requesters hold the pipeline through their own stall requests to stall ctrl until done.
// PARAMETERS
//  ADDR_W  32  width of every address port
//  DATA_W  32  width of assembled read/write data (4 bytes)
// PORTS
//  clk_in       in   1   system clock
//  rst_in       in   1   asynchronous, active-low reset
//  rdy_in       in   1   global ready; low = pause
//  flush_in     in   1   branch/jump mispredict flush from EX
//  if_req_i     in   1   IF fetch request, held until if_done_o
//  if_addr_i    in   32  fetch address
//  if_done_o    out  1   one-cycle pulse: if_data_o valid
//  if_data_o    out  32  fetched instruction
//  mem_req_i    in   1   MEM access request, held until mem_done_o
//  mem_wr_i     in   1   1 = store, 0 = load
//  mem_len_i    in   2   `LenByte=00, `LenHalf=01, `LenWord=10
//  mem_addr_i   in   32  access base address
//  mem_wdata_i  in   32  store data, byte k = [8k+7:8k]
//  mem_done_o   out  1   one-cycle pulse: load data valid / store complete
//  mem_rdata_o  out  32  load data, zero-extended (MEM sign-extends)
//  ram_din_i    in   8   RAM read byte; valid the cycle after its address
//  ram_dout_o   out  8   RAM write byte
//  ram_a_o      out  32  RAM byte address
//  ram_wr_o     out  1   1 = write, 0 = read
// BEHAVIOUR
//  Reset (async, rst_in=0):
//   - state=IDLE.
//   - All outputs, counters and the assembly register are 0.
//  States: IDLE, IF_RD, MEM_RD, MEM_WR, BUBBLE.
//  IDLE grant rules:
//   - mem_req_i has priority over if_req_i; MEM is older and a MEM stall blocks IF anyway.
//   - Grant loads base address and byte count N (IF: 4; MEM: 1/2/4 from len) and clears k.
//   - No preemption once a transfer has started.
//  Read timing (req seen in cycle 0):
//   - ram_a_o = base+k in cycle 1+k, for k = 0..N-1.
//   - ram_din_i is captured into byte k at the end of cycle 2+k.
//   - done_o is high in cycle N+2: word read = cycle 6, byte read = cycle 3.
//  Write timing:
//   - In cycle 1+k: ram_a_o = base+k, ram_dout_o = wdata byte k, ram_wr_o = 1.
//   - done_o is high in cycle N+1: word store = cycle 5.
//  Done cycle and BUBBLE:
//   - The done pulse is registered and is asserted in the BUBBLE cycle.
//   - BUBBLE grants nothing, so a requester still showing req that cycle is not re-served.
//   - BUBBLE -> IDLE.
//  Data outputs:
//   - if_data_o / mem_rdata_o hold their last value until the next done of that requester.
//   - Unused high bytes are 0.
//  ram_wr_o is 0 in every state except an active MEM_WR byte cycle. Address arithmetic is 32-bit wrap.
//  flush_in:
//   - In IF_RD: abort to IDLE next cycle. No if_done_o pulse; partial data is discarded.
//   - In IDLE: an IF grant in that same cycle is suppressed.
//   - MEM_RD / MEM_WR and BUBBLE: ignored (the MEM op is older than the branch).
//  rdy_in=0:
//   - State, k and the assembly register hold; ram_wr_o is forced to 0.
//   - The byte in flight is discarded. On the first cycle with rdy_in=1 the current byte address is
//     re-issued, so each pause costs pause_len+1 cycles.
//   - No byte is ever written twice or skipped.
//  Simultaneous flush_in and rdy_in=0 in IF_RD: flush wins.
// STRUCTURE
//  - Into the shared defines header: state encodings and `LenByte/`LenHalf/`LenWord.
//  - Everything else lives in this module.
//  - One natural sub-module: mem_byte_pack (len + byte index -> write byte mux and read byte-lane enable),
//    purely combinational.
// TESTING
//  - IF fetch 0x100, RAM[0x100..0x103] = 13 00 00 93 -> if_done_o in cycle 6, if_data_o = 0x93000013.
//  - mem_req (SW 0xDEADBEEF @0x200) and if_req (@0x104) in the same cycle -> RAM writes EF BE AD DE at
//    0x200..0x203 in cycles 1-4, mem_done_o in cycle 5, BUBBLE, then the IF grant.
//  - LB @0x203 after the test above -> mem_done_o in cycle 3, mem_rdata_o = 0x000000DE.
//    LHU @0x202 -> 0x0000DEAD in cycle 4.
//  - flush_in in cycle 3 of an IF fetch with mem_req pending -> no if_done_o, IDLE next cycle,
//    then the MEM grant.
//  - rdy_in=0 for 3 cycles during SH 0x1234 @0x300 -> no ram_wr_o during the pause.
//    RAM[0x300]=34, RAM[0x301]=12, each written exactly once; mem_done_o 4 cycles late.
//  - rst_in=0 mid MEM_RD -> all outputs 0 immediately (async). After release: IDLE, no stray done pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM bus arbiter: FSM states, access lengths and the
// length-to-byte-count helper.
package mem_arbiter_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIfRd   = 3'd1;
  localparam logic [2:0] StMemRd  = 3'd2;
  localparam logic [2:0] StMemWr  = 3'd3;
  localparam logic [2:0] StBubble = 3'd4;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  // The undefined encoding 2'b11 is treated as a word access.
  function automatic logic [2:0] len_to_count(input logic [1:0] len);
    logic [2:0] cnt;
    case (len)
      LenByte: cnt = 3'd1;
      LenHalf: cnt = 3'd2;
      default: cnt = 3'd4;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/mem_byte_pack.sv
// Byte-lane helper: selects the store byte for index idx_i and flags the read lane
// that index idx_i fills, both limited to the byte count of the access length.
module mem_byte_pack
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]          len_i,
  input  logic [2:0]          idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [7:0]          wbyte_o,
  output logic [DATA_W/8-1:0] lane_en_o,
  output logic                last_o
);

  logic [2:0] count;

  assign count  = len_to_count(len_i);
  assign last_o = ((idx_i + 3'd1) == count);

  always_comb begin
    wbyte_o   = '0;
    lane_en_o = '0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      if ((idx_i == 3'(b)) && (idx_i < count)) begin
        wbyte_o      = wdata_i[8*b +: 8];
        lane_en_o[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Owner of the 8-bit RAM bus: serves IF word fetches and MEM loads/stores as byte
// sequences, reassembles little-endian, and returns a registered one-cycle done.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  localparam int unsigned NumBytes = DATA_W / 8;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        len_q, len_d;
  logic [2:0]        k_q, k_d;
  logic              pend_q, pend_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic [7:0]          wbyte;
  logic [NumBytes-1:0] lane_en;
  logic                last_byte;
  logic [DATA_W-1:0]   asm_cap;
  logic [2:0]          a_idx;
  logic                ram_wr;

  mem_byte_pack #(
    .DATA_W (DATA_W)
  ) u_byte_pack (
    .len_i     (len_q),
    .idx_i     (k_q),
    .wdata_i   (wdata_q),
    .wbyte_o   (wbyte),
    .lane_en_o (lane_en),
    .last_o    (last_byte)
  );

  // Byte k_q arriving on ram_din_i merged into the assembly register.
  always_comb begin
    asm_cap = asm_q;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if (lane_en[b]) begin
        asm_cap[8*b +: 8] = ram_din_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    k_d         = k_q;
    pend_d      = pend_q;
    stall_d     = stall_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr      = 1'b0;
    a_idx       = k_q;

    // While a read byte is in flight, the next address is already on the bus.
    if ((state_q == StIfRd || state_q == StMemRd) && pend_q) begin
      a_idx = k_q + 3'd1;
    end

    case (state_q)
      StIdle: begin
        if (rdy_in) begin
          if (mem_req_i) begin
            state_d = mem_wr_i ? StMemWr : StMemRd;
            base_d  = mem_addr_i;
            len_d   = mem_len_i;
            wdata_d = mem_wdata_i;
            k_d     = 3'd0;
            pend_d  = 1'b0;
            stall_d = 1'b0;
            asm_d   = '0;
          end else if (if_req_i && !flush_in) begin
            state_d = StIfRd;
            base_d  = if_addr_i;
            len_d   = LenWord;
            k_d     = 3'd0;
            pend_d  = 1'b0;
            stall_d = 1'b0;
            asm_d   = '0;
          end
        end
      end

      StIfRd, StMemRd: begin
        if (state_q == StIfRd && flush_in) begin
          state_d = StIdle;
          pend_d  = 1'b0;
        end else if (!rdy_in) begin
          pend_d = 1'b0;
        end else if (pend_q) begin
          asm_d = asm_cap;
          if (last_byte) begin
            state_d = StBubble;
            pend_d  = 1'b0;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_data_d = asm_cap;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_cap;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end else begin
          pend_d = 1'b1;
        end
      end

      StMemWr: begin
        if (!rdy_in) begin
          stall_d = 1'b1;
        end else if (stall_q) begin
          // First cycle after a pause re-presents the address without writing.
          stall_d = 1'b0;
        end else begin
          ram_wr = 1'b1;
          if (last_byte) begin
            state_d    = StBubble;
            mem_done_d = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      StBubble: begin
        if (rdy_in) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= LenByte;
      k_q         <= '0;
      pend_q      <= 1'b0;
      stall_q     <= 1'b0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      stall_q     <= stall_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_wr_o    = ram_wr;
  assign ram_dout_o  = (state_q == StMemWr) ? wbyte : 8'h00;
  assign ram_a_o     = base_q + ADDR_W'(a_idx);

endmodule
